feature_vector_writer: RTL and testbench

Parametrised successor to the PL→PS output stage. Accepts a byte-element stream delimited by valid_in and packs PACK elements per BRAM word into ping-pong banks of a true-dual-port BRAM; the PS reads the other port. On each burst end it commits the bank and pulses vec_done with length and bank. The PS releases banks with ps_ack, and bursts arriving with both banks full are dropped and counted.

---
 rtl/fvw_pkg.sv | 27 ++
 rtl/fvw_lane_packer.sv | 59 +++++
 rtl/feature_vector_writer.sv | 191 +++++++++++++++++++
 tb/tb_feature_vector_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fvw_pkg.sv
// Shared state encoding and sizing helpers for feature_vector_writer.
// Defining OUT_CHECKSUM_EN adds the TRAIL state and reserves one word per bank for the trailer.
package fvw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DROP
`ifdef OUT_CHECKSUM_EN
    , TRAIL
`endif
  } state_t;

  // The trailer needs a free word after the last data word, so the bank gives up one word.
  function automatic int max_elems(input int pack, input int depth_w);
`ifdef OUT_CHECKSUM_EN
    return pack * ((1 << depth_w) - 1);
`else
    return pack << depth_w;
`endif
  endfunction

  function automatic int lane_w(input int pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

endpackage

// File: rtl/fvw_lane_packer.sv
// Packs DATA_W elements into PACK-lane words; emits the word write (comb) when the last
// lane fills, or a partial word with only the filled lanes enabled on flush.
module fvw_lane_packer
  import fvw_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PACK   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        data,
  output logic [PACK-1:0]          we,
  output logic [DATA_W*PACK-1:0]   din
);

  localparam int LW = lane_w(PACK);
  localparam logic [LW-1:0] LAST = LW'(PACK - 1);

  logic [LW-1:0]          lane_q, lane_d;
  logic [DATA_W*PACK-1:0] pack_q, pack_d, merged;

  always_comb begin
    merged = pack_q;
    merged[lane_q*DATA_W +: DATA_W] = data;
    lane_d = lane_q;
    pack_d = pack_q;
    we     = '0;
    din    = pack_q;
    if (push) begin
      if (lane_q == LAST) begin
        we     = '1;
        din    = merged;
        pack_d = '0;
        lane_d = '0;
      end else begin
        pack_d = merged;
        lane_d = lane_q + LW'(1);
      end
    end else if (flush && (lane_q != '0)) begin
      // Unfilled lanes are held at zero, so only the enables need masking.
      for (int i = 0; i < PACK; i++) we[i] = (LW'(i) < lane_q);
      pack_d = '0;
      lane_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/feature_vector_writer.sv
// Ping-pong BRAM writer: packs element bursts into banks, commits with vec_done, drops when full.
// Optional OUT_CHECKSUM_EN appends a checksum trailer word after each committed burst.
module feature_vector_writer
  import fvw_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PACK    = 4,
  parameter int DEPTH_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     bram_en,
  output logic [PACK-1:0]          bram_we,
  output logic [DEPTH_W:0]         bram_addr,
  output logic [DATA_W*PACK-1:0]   bram_din,
  output logic                     vec_done,
  output logic [CNT_W-1:0]         vec_len,
  output logic                     vec_bank,
  input  logic                     ps_ack,
  input  logic                     ps_ack_bank,
  output logic [1:0]               bank_full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int MAX_ELEMS = max_elems(PACK, DEPTH_W);
  localparam int CW        = $clog2(MAX_ELEMS + 1);
  localparam int SH        = $clog2(PACK);
  localparam int WW        = DATA_W * PACK;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_ELEMS);

  state_t            state_q, state_d;
  logic              wbank_q, wbank_d, bank_c;
  logic [CW-1:0]     cnt_q, cnt_c, cnt_d;
  logic              push, flush, commit, done_d, ovf_d, vbank_d;
  logic [CNT_W-1:0]  drop_d, len_d;
  logic [1:0]        ack_mask, set_mask, full_d;
  logic [PACK-1:0]   pk_we, we_c;
  logic [WW-1:0]     pk_din, din_c;
  logic [DEPTH_W:0]  addr_c;

  fvw_lane_packer #(.DATA_W(DATA_W), .PACK(PACK)) u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .flush (flush),
    .data  (data_in),
    .we    (pk_we),
    .din   (pk_din)
  );

  always_comb begin
    state_d = state_q;
    wbank_d = wbank_q;
    bank_c  = wbank_q;
    cnt_c   = cnt_q;
    push    = 1'b0;
    flush   = 1'b0;
    commit  = 1'b0;
    done_d  = 1'b0;
    ovf_d   = overflow;
    drop_d  = drop_cnt;
    len_d   = vec_len;
    vbank_d = vec_bank;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          cnt_c = '0;
          // Prefer the bank after the last commit; fall back to the other one.
          if (!bank_full[wbank_q]) begin
            state_d = WRITE;
            push    = 1'b1;
          end else if (!bank_full[~wbank_q]) begin
            state_d = WRITE;
            push    = 1'b1;
            bank_c  = ~wbank_q;
            wbank_d = ~wbank_q;
          end else begin
            state_d = DROP;
          end
        end
      end
      WRITE: begin
        if (valid_in) begin
          if (cnt_q < MAX_C) push = 1'b1;
          else               ovf_d = 1'b1;
        end else begin
          flush   = 1'b1;
          commit  = 1'b1;
          len_d   = CNT_W'(cnt_q);
          vbank_d = wbank_q;
          wbank_d = ~wbank_q;
`ifdef OUT_CHECKSUM_EN
          state_d = TRAIL;
`else
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end
      end
      DROP: begin
        if (!valid_in) begin
          if (drop_cnt != '1) drop_d = drop_cnt + CNT_W'(1);
          state_d = IDLE;
        end
      end
`ifdef OUT_CHECKSUM_EN
      TRAIL: begin
        done_d  = 1'b1;
        state_d = valid_in ? DROP : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    cnt_d = push ? cnt_c + CW'(1) : cnt_c;
  end

  // A commit and an ack on the same bank leave it full.
  always_comb begin
    ack_mask = 2'b00;
    set_mask = 2'b00;
    if (ps_ack) ack_mask[ps_ack_bank] = 1'b1;
    if (commit) set_mask[wbank_q]     = 1'b1;
    full_d = (bank_full & ~ack_mask) | set_mask;
  end

`ifdef OUT_CHECKSUM_EN
  logic [WW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = (state_q == IDLE) ? '0 : sum_q;
    if (push) sum_d = sum_d + WW'(data_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
`endif

  always_comb begin
    we_c   = pk_we;
    din_c  = pk_din;
    addr_c = {bank_c, DEPTH_W'(cnt_c >> SH)};
`ifdef OUT_CHECKSUM_EN
    if (state_q == TRAIL) begin
      we_c   = '1;
      din_c  = sum_q;
      addr_c = {vec_bank, DEPTH_W'((cnt_q + CW'(PACK - 1)) >> SH)};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wbank_q   <= 1'b0;
      cnt_q     <= '0;
      bank_full <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      vec_len   <= '0;
      vec_bank  <= 1'b0;
      vec_done  <= 1'b0;
      bram_en   <= 1'b0;
      bram_we   <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      state_q   <= state_d;
      wbank_q   <= wbank_d;
      cnt_q     <= cnt_d;
      bank_full <= full_d;
      overflow  <= ovf_d;
      drop_cnt  <= drop_d;
      vec_len   <= len_d;
      vec_bank  <= vbank_d;
      vec_done  <= done_d;
      bram_en   <= |we_c;
      bram_we   <= we_c;
      if (|we_c) begin
        bram_addr <= addr_c;
        bram_din  <= din_c;
      end
    end
  end

endmodule

// File: tb/tb_feature_vector_writer.sv
// Directed bench for feature_vector_writer (DATA_W=8, PACK=4, DEPTH_W=4, default build).
module tb_feature_vector_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [4:0]  bram_addr;
  logic [31:0] bram_din;
  logic        vec_done;
  logic [15:0] vec_len;
  logic        vec_bank;
  logic        ps_ack;
  logic        ps_ack_bank;
  logic [1:0]  bank_full;
  logic        overflow;
  logic [15:0] drop_cnt;

  feature_vector_writer #(.DATA_W(8), .PACK(4), .DEPTH_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .vec_done    (vec_done),
    .vec_len     (vec_len),
    .vec_bank    (vec_bank),
    .ps_ack      (ps_ack),
    .ps_ack_bank (ps_ack_bank),
    .bank_full   (bank_full),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [3:0]  we;
    logic [31:0] din;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [15:0] len;
    logic        bank;
    logic [1:0]  full;
    int          cyc;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  wr_t mon_w;
  dn_t mon_d;
  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;
  int  s, s2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Record every BRAM write and every vec_done pulse as seen away from the clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_en || (bram_we != 4'b0)) begin
        chk("en_or_we", 32'(bram_en), 32'(|bram_we));
        mon_w.addr = bram_addr;
        mon_w.we   = bram_we;
        mon_w.din  = bram_din;
        mon_w.cyc  = cyc;
        wq.push_back(mon_w);
      end
      if (vec_done) begin
        mon_d.len  = vec_len;
        mon_d.bank = vec_bank;
        mon_d.full = bank_full;
        mon_d.cyc  = cyc;
        dq.push_back(mon_d);
      end
    end
  end

  task automatic check_wr(input string tag, input int i, input logic [4:0] a,
                          input logic [3:0] we, input logic [31:0] d);
    if (i < wq.size()) begin
      chk({tag, "_addr"}, 32'(wq[i].addr), 32'(a));
      chk({tag, "_we"},   32'(wq[i].we),   32'(we));
      chk({tag, "_din"},  wq[i].din,       d);
    end else begin
      chk({tag, "_missing"}, 32'(wq.size()), 32'(i + 1));
    end
  endtask

  task automatic check_done(input string tag, input int i, input logic [15:0] len,
                            input logic bank, input logic [1:0] full);
    if (i < dq.size()) begin
      chk({tag, "_len"},  32'(dq[i].len),  32'(len));
      chk({tag, "_bank"}, 32'(dq[i].bank), 32'(bank));
      chk({tag, "_full"}, 32'(dq[i].full), 32'(full));
    end else begin
      chk({tag, "_missing"}, 32'(dq.size()), 32'(i + 1));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      ps_ack = 1'b0;
    end
  endtask

  task automatic ack(input logic b);
    @(negedge clk);
    ps_ack      = 1'b1;
    ps_ack_bank = b;
    @(negedge clk);
    ps_ack      = 1'b0;
  endtask

  // Drives n consecutive elements first, first+1, ...; the end cycle can carry an ack.
  task automatic send_burst(input int n, input logic [7:0] first, input logic do_ack,
                            input logic ack_b, output int start);
    start = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) start = cyc;
      ps_ack   = 1'b0;
      valid_in = 1'b1;
      data_in  = first + 8'(i);
    end
    @(negedge clk);
    valid_in    = 1'b0;
    data_in     = 8'h00;
    ps_ack      = do_ack;
    ps_ack_bank = ack_b;
  endtask

  task automatic clear_logs();
    wq.delete();
    dq.delete();
  endtask

  initial begin
    logic [31:0] e;
    rst_n       = 1'b0;
    valid_in    = 1'b0;
    data_in     = 8'h00;
    ps_ack      = 1'b0;
    ps_ack_bank = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bram_en",   32'(bram_en),   32'h0);
    chk("rst_vec_done",  32'(vec_done),  32'h0);
    chk("rst_bank_full", 32'(bank_full), 32'h0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'h0);
    chk("rst_overflow",  32'(overflow),  32'h0);
    chk("rst_vec_len",   32'(vec_len),   32'h0);
    rst_n = 1'b1;
    tick(2);

    // 1: six elements, one full word then a two-lane flush
    clear_logs();
    send_burst(6, 8'h01, 1'b0, 1'b0, s);
    tick(3);
    chk("t1_nwr", 32'(wq.size()), 32'd2);
    check_wr("t1_w0", 0, 5'h00, 4'hF, 32'h04030201);
    check_wr("t1_w1", 1, 5'h01, 4'h3, 32'h00000605);
    if (wq.size() >= 2) begin
      chk("t1_w0_cyc", 32'(wq[0].cyc), 32'(s + 4));
      chk("t1_w1_cyc", 32'(wq[1].cyc), 32'(s + 7));
    end
    chk("t1_ndone", 32'(dq.size()), 32'd1);
    check_done("t1_done", 0, 16'd6, 1'b0, 2'b01);
    if (dq.size() >= 1) chk("t1_done_cyc", 32'(dq[0].cyc), 32'(s + 7));

    // 2: single element lands in bank 1
    clear_logs();
    send_burst(1, 8'hAA, 1'b0, 1'b0, s);
    tick(3);
    chk("t2_nwr", 32'(wq.size()), 32'd1);
    check_wr("t2_w0", 0, 5'h10, 4'h1, 32'h000000AA);
    chk("t2_ndone", 32'(dq.size()), 32'd1);
    check_done("t2_done", 0, 16'd1, 1'b1, 2'b11);

    // 3: both banks full -> drop; then release bank 0 and write it
    clear_logs();
    send_burst(3, 8'h30, 1'b0, 1'b0, s);
    tick(3);
    chk("t3_drop_nwr",   32'(wq.size()), 32'd0);
    chk("t3_drop_ndone", 32'(dq.size()), 32'd0);
    chk("t3_drop_cnt",   32'(drop_cnt),  32'd1);
    ack(1'b0);
    chk("t3_full_ack", 32'(bank_full), 32'h2);
    clear_logs();
    send_burst(4, 8'h11, 1'b0, 1'b0, s);
    tick(3);
    chk("t3_nwr", 32'(wq.size()), 32'd1);
    check_wr("t3_w0", 0, 5'h00, 4'hF, 32'h14131211);
    check_done("t3_done", 0, 16'd4, 1'b0, 2'b11);

    // 4: 70 elements truncated at 64
    ack(1'b0);
    clear_logs();
    send_burst(70, 8'h01, 1'b0, 1'b0, s);
    tick(3);
    chk("t4_nwr", 32'(wq.size()), 32'd16);
    for (int w = 0; w < 16; w++) begin
      e = {8'(4*w + 4), 8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1)};
      check_wr($sformatf("t4_w%0d", w), w, 5'(w), 4'hF, e);
    end
    chk("t4_ndone", 32'(dq.size()), 32'd1);
    check_done("t4_done", 0, 16'd64, 1'b0, 2'b11);
    chk("t4_overflow", 32'(overflow), 32'h1);
    ack(1'b1);
    clear_logs();
    send_burst(2, 8'h81, 1'b0, 1'b0, s);
    tick(3);
    check_wr("t4b_w0", 0, 5'h10, 4'h3, 32'h00008281);
    check_done("t4b_done", 0, 16'd2, 1'b1, 2'b11);
    chk("t4b_overflow", 32'(overflow), 32'h1);

    // 5: commit bank 1 with same-cycle ack of bank 0, then back-to-back burst
    ack(1'b1);
    clear_logs();
    send_burst(3, 8'h51, 1'b1, 1'b0, s);
    send_burst(5, 8'h61, 1'b0, 1'b0, s2);
    tick(3);
    chk("t5_nwr", 32'(wq.size()), 32'd3);
    check_wr("t5_a",  0, 5'h10, 4'h7, 32'h00535251);
    check_wr("t5_b0", 1, 5'h00, 4'hF, 32'h64636261);
    check_wr("t5_b1", 2, 5'h01, 4'h1, 32'h00000065);
    chk("t5_ndone", 32'(dq.size()), 32'd2);
    check_done("t5_da", 0, 16'd3, 1'b1, 2'b10);
    check_done("t5_db", 1, 16'd5, 1'b0, 2'b11);

    // 6: asynchronous reset in the middle of a burst
    ack(1'b0);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 8'h91;
    @(negedge clk);
    data_in  = 8'h92;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_bank_full", 32'(bank_full), 32'h0);
    chk("t6_vec_len",   32'(vec_len),   32'h0);
    chk("t6_overflow",  32'(overflow),  32'h0);
    chk("t6_drop_cnt",  32'(drop_cnt),  32'h0);
    chk("t6_bram_en",   32'(bram_en),   32'h0);
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    clear_logs();
    send_burst(4, 8'h71, 1'b0, 1'b0, s);
    tick(3);
    chk("t6_nwr", 32'(wq.size()), 32'd1);
    check_wr("t6_w0", 0, 5'h00, 4'hF, 32'h74737271);
    check_done("t6_done", 0, 16'd4, 1'b0, 2'b01);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
